viterbi_k3_decoder: RTL and testbench

// - Hard-decision Viterbi decoder for a rate-1/2, constraint-length-3 convolutional code.
// - Generators are G1=7 (111) and G0=5 (101).
// - Sits at the receive end of the tx/rx chain: {encoder -> noisy channel -> this block}.
// - Consumes one 2-bit code symbol per enabled clock and emits one decoded info bit per enabled clock.
// - Latency is fixed by the survivor depth.
// - Matching encoder (golden model for verification):
//   - state {r1,r0}, r1 = newest bit, reset state 00;
//   - out[1] = b^r1^r0, out[0] = b^r0;
//   - next state = {b,r1}.

---
 rtl/viterbi_k3_decoder.sv | 154 +++++++++++++++
 tb/tb_viterbi_k3_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_k3_decoder.sv
// -----------------------------------------------------------------------------
// viterbi_k3_decoder
//
// Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code with
// generators G1=7 (111) and G0=5 (101). It sits at the receive end of the
// link and takes one 2-bit code symbol per enabled clock. It produces one
// decoded info bit per enabled clock. Survivors are kept by register exchange,
// so decode latency is fixed at TB_DEPTH-1 enabled symbols.
//
// Trellis convention (matches the transmit encoder):
//   state {r1,r0}, r1 = newest bit; input b emits {b^r1^r0, b^r0} and moves
//   to state {b,r1}. Decoding starts from state 00.
//
// Parameters
//   TB_DEPTH  survivor length in bits (>= 16); sets the decode latency.
//   PM_W      path-metric width in bits (unsigned, >= 6 so the initial 63 fits).
//
// Ports
//   clk     clock; all state changes on the rising edge
//   rst     asynchronous, active-low reset
//   enable  symbol valid; nothing changes on cycles where it is low
//   d_in    received code symbol {G1 bit, G0 bit}
//   d_out   decoded info bit (registered); no valid strobe is provided
// -----------------------------------------------------------------------------
module viterbi_k3_decoder #(
  parameter int TB_DEPTH = 32,
  parameter int PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  typedef logic [PM_W-1:0]     pm_t;
  typedef logic [PM_W:0]       sum_t;
  typedef logic [TB_DEPTH-1:0] surv_t;

  localparam pm_t PM_MAX  = '1;
  // Non-zero start states get a large metric so decoding is anchored at 00.
  localparam pm_t PM_INIT = PM_W'(63);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Hamming distance between the received symbol and the symbol the encoder
  // would have sent when leaving state `pred` with input `b`.
  function automatic logic [1:0] branch_metric(input logic [1:0] pred,
                                               input logic       b,
                                               input logic [1:0] sym);
    logic [1:0] expected;
    logic [1:0] diff;
    expected = {b ^ pred[1] ^ pred[0], b ^ pred[0]};
    diff     = expected ^ sym;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // Clamp a one-bit-wider sum back into the metric range instead of wrapping.
  function automatic pm_t saturate(input sum_t value);
    return value[PM_W] ? PM_MAX : value[PM_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pm_t   pm_q   [4];
  pm_t   pm_d   [4];
  surv_t surv_q [4];
  surv_t surv_d [4];
  logic  d_out_q;
  logic  d_out_d;

  // ACS results before normalisation
  sum_t       cand0    [4];
  sum_t       cand1    [4];
  logic       take_p1  [4];
  pm_t        acs_pm   [4];
  surv_t      acs_surv [4];
  logic [1:0] best_state;

  // ---------------------------------------------------------------------------
  // Add-compare-select
  // Next state s = {b, r1} is reached from p0 = {r1,0} and p1 = {r1,1}, so
  // b = s[1] and r1 = s[0]. Strict less-than makes p0 win ties.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      cand0[s]    = {1'b0, pm_q[{s[0], 1'b0}]}
                  + (PM_W+1)'(branch_metric({s[0], 1'b0}, s[1], d_in));
      cand1[s]    = {1'b0, pm_q[{s[0], 1'b1}]}
                  + (PM_W+1)'(branch_metric({s[0], 1'b1}, s[1], d_in));
      take_p1[s]  = cand1[s] < cand0[s];
      acs_pm[s]   = take_p1[s] ? saturate(cand1[s]) : saturate(cand0[s]);
      // Register exchange: inherit the winner's history, newest bit at LSB.
      acs_surv[s] = {surv_q[{s[0], take_p1[s]}][TB_DEPTH-2:0], s[1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Best state: smallest new metric, lowest index on ties. It both sets the
  // normalisation offset and chooses which survivor drives d_out.
  // ---------------------------------------------------------------------------
  always_comb begin
    best_state = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (acs_pm[s] < acs_pm[best_state]) best_state = 2'(s);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a hold default first; otherwise the enable=0
    // path would leave these unassigned and infer latches.
    pm_d    = pm_q;
    surv_d  = surv_q;
    d_out_d = d_out_q;
    if (enable) begin
      for (int s = 0; s < 4; s++) begin
        // Subtracting the minimum keeps the smallest metric at 0, so metrics
        // stay small and saturation only guards the unreachable corner.
        pm_d[s] = acs_pm[s] - acs_pm[best_state];
      end
      surv_d  = acs_surv;
      d_out_d = acs_surv[best_state][TB_DEPTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the survivors are ordinary flops, not a RAM, so they take the
  // asynchronous reset as well. A restart must not replay stale history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
      d_out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pm_q    <= pm_d;
      surv_q  <= surv_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_k3_decoder.sv
// -----------------------------------------------------------------------------
// tb_viterbi_k3_decoder
//
// Scoreboard bench for viterbi_k3_decoder. The driver encodes info bits
// directly as the convolution with 111 and 101 of the info sequence. It may
// corrupt symbols and it may gap the enable. For every enabled symbol it
// pushes the bit expected on d_out after that edge: the info bit TB_DEPTH-1
// symbols earlier, or 0 before that. A monitor samples on the falling edge.
// After each enabled edge it pops and compares. After a disabled edge it
// checks that d_out held. While reset is low it checks that d_out is 0.
// -----------------------------------------------------------------------------
module tb_viterbi_k3_decoder;

  localparam int TB_DEPTH = 32;
  localparam int PM_W     = 8;
  localparam int LAT      = TB_DEPTH - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;

  viterbi_k3_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d_in   (d_in),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  int n_vec     = 0;
  int n_fail    = 0;
  int inj_count = 0;
  bit exp_q[$];
  bit last_exp  = 1'b0;
  bit info[$];
  bit clean_bits[$];

  task automatic check(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0b expected %0b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Info bit i of the current stream; bits before the stream are 0.
  function automatic bit info_at(input int i);
    return (i < 0) ? 1'b0 : info[i];
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit en_seen;
    bit e;
    forever begin
      @(posedge clk);
      en_seen = enable && rst;
      @(negedge clk);
      if (!rst) begin
        check("reset_dout", d_out, 1'b0);
      end else if (en_seen) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL no_expectation @%0t: got %0b expected none", $time, d_out);
        end else begin
          e = exp_q.pop_front();
          check("decoded_bit", d_out, e);
          last_exp = e;
        end
      end else begin
        check("hold_dout", d_out, last_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------

  // Assert reset mid-cycle and check that it acts at once. Toggle enable
  // while reset is held, then release and idle with no enabled symbols.
  task automatic do_reset();
    @(negedge clk); #1;
    rst      = 1'b0;
    enable   = 1'b0;
    exp_q.delete();
    last_exp = 1'b0;
    #1 check("async_reset_dout", d_out, 1'b0);
    repeat (4) begin
      @(negedge clk); #1;
      enable = ~enable;
      d_in   = 2'($urandom);
    end
    @(negedge clk); #1;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      d_in = 2'($urandom);
    end
  endtask

  // Feed info[0..n-1]. The symbol for bit k is
  // {b[k]^b[k-1]^b[k-2], b[k]^b[k-2]}.
  task automatic play(input int n, input bit gapped, input bit inject, input bit drain);
    logic [1:0] sym;
    for (int k = 0; k < n; k++) begin
      sym = {info_at(k) ^ info_at(k-1) ^ info_at(k-2), info_at(k) ^ info_at(k-2)};
      if (inject && k < 256 && (k % 16) == 0) begin
        sym[0] = ~sym[0];
        inj_count++;
      end
      if (gapped) begin
        @(negedge clk); #1;
        enable = 1'b0;
        d_in   = 2'($urandom);
      end
      @(negedge clk); #1;
      enable = 1'b1;
      d_in   = sym;
      exp_q.push_back((k >= LAT) ? info[k-LAT] : 1'b0);
    end
    @(negedge clk); #1;
    enable = 1'b0;
    d_in   = 2'($urandom);
    if (drain) check_int("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : driver
    rst    = 1'b0;
    enable = 1'b0;
    d_in   = 2'b00;

    // Reset behaviour and idle after release.
    do_reset();

    // Clean channel.
    clean_bits.delete();
    for (int i = 0; i < 300; i++) clean_bits.push_back(1'($urandom));
    info = clean_bits;
    play(300, 1'b0, 1'b0, 1'b1);

    // Single-bit errors every 16th symbol over the first 256 symbols.
    do_reset();
    inj_count = 0;
    info = clean_bits;
    play(300, 1'b0, 1'b1, 1'b1);
    check_int("injected_errors", inj_count, 16);

    // Same stream, enable on alternate cycles with junk on idle cycles.
    do_reset();
    info = clean_bits;
    play(300, 1'b1, 1'b0, 1'b1);

    // Constant streams.
    do_reset();
    info.delete();
    for (int i = 0; i < 64; i++) info.push_back(1'b0);
    play(64, 1'b0, 1'b0, 1'b1);

    do_reset();
    info.delete();
    for (int i = 0; i < 64; i++) info.push_back(1'b1);
    play(64, 1'b0, 1'b0, 1'b1);

    // Mid-stream reset after 100 symbols. Bit 68 is forced to 1 so d_out is
    // high just before reset.
    do_reset();
    info.delete();
    for (int i = 0; i < 100; i++) info.push_back(1'($urandom));
    info[100-1-LAT] = 1'b1;
    play(100, 1'b0, 1'b0, 1'b1);
    do_reset();
    info = clean_bits;
    play(300, 1'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog: the sequence needs only a few thousand cycles.
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog @%0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
